mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 24 ++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the memory arbiter
package mem_arb_pkg;

    localparam int NREQ       = 2;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin tie-break, grant one-hot plus index
module rr_arbiter2 (
    input  logic [1:0] i_req_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_id
);

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        o_id    = 1'b0;
        o_grant = 2'b00;
        case (i_req_valid)
            2'b01:   o_id = 1'b0;
            2'b10:   o_id = 1'b1;
            2'b11:   o_id = ~i_last_grant;
            default: o_id = 1'b0;
        endcase
        if (i_req_valid != 2'b00) begin
            o_grant[o_id] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin sequencer for a single-port memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic                     rsp_valid,
    output logic                     rsp_id,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_we,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [NREQ*CNT_W-1:0]    grant_cnt
);

    state_t                        r_state;
    logic                          r_last_grant;
    logic                          r_id;
    logic                          r_we;
    logic [ADDR_W-1:0]             r_mem_addr;
    logic [DATA_W-1:0]             r_mem_wdata;
    logic                          r_mem_we;
    logic                          r_rsp_valid;
    logic                          r_rsp_id;
    logic [DATA_W-1:0]             r_rsp_rdata;
    logic [NREQ-1:0][CNT_W-1:0]    r_grant_cnt;

    logic [NREQ-1:0]               w_grant;
    logic                          w_id;
    logic                          w_accept;
    logic                          w_sel_we;
    logic [ADDR_W-1:0]             w_sel_addr;
    logic [DATA_W-1:0]             w_sel_wdata;

    rr_arbiter2 u_rr (
        .i_req_valid  (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_id         (w_id)
    );

    // Ready only in IDLE; the winner's fields are muxed for latching on accept.
    always_comb begin
        req_ready   = (r_state == ST_IDLE) ? w_grant : '0;
        w_accept    = |(req_valid & req_ready);
        w_sel_we    = req_we[w_id];
        w_sel_addr  = w_id ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
        w_sel_wdata = w_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end

    // Transaction sequencer: latch on accept, drive memory, return one tagged response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_we         <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_rdata  <= '0;
            r_grant_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (w_accept) begin
                        r_id         <= w_id;
                        r_we         <= w_sel_we;
                        r_mem_addr   <= w_sel_addr;
                        r_mem_wdata  <= w_sel_wdata;
                        r_mem_we     <= w_sel_we;
                        r_last_grant <= w_id;
                        if (r_grant_cnt[w_id] != '1) begin
                            r_grant_cnt[w_id] <= r_grant_cnt[w_id] + 1'b1;
                        end
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Read data settles during this cycle and is captured here.
                    r_mem_we    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_rsp_rdata <= r_we ? '0 : mem_rdata;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_mem_we    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_rdata = r_rsp_rdata;
    assign grant_cnt = r_grant_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_we = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [31:0] grant_cnt;

    logic [1:0]  s_valid = '0;
    logic [1:0]  s_ready;
    logic        s_rsp_valid;
    logic        s_rsp_id;
    logic [15:0] s_rsp_rdata;
    logic [15:0] s_mem_addr;
    logic [15:0] s_mem_wdata;
    logic        s_mem_we;
    logic [3:0]  s_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int we_cycles = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .grant_cnt(grant_cnt)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_valid), .req_ready(s_ready), .req_we(2'b00),
        .req_addr(32'h0), .req_wdata(32'h0),
        .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_rdata(s_rsp_rdata),
        .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_we(s_mem_we),
        .mem_rdata(16'h0), .grant_cnt(s_cnt)
    );

    // Memory device: combinational read, write on the clock edge.
    logic [15:0] mem [0:65535];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_we) we_cycles <= we_cycles + 1;

    typedef struct { logic id; logic [15:0] data; int t; } rsp_t;
    typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; } txn_t;
    typedef struct { logic id; logic [15:0] data; } exp_t;

    rsp_t rq[$];
    always @(negedge clk) if (rsp_valid) rq.push_back('{rsp_id, rsp_rdata, cyc});

    // Reference model state
    logic [15:0] mm [int];
    logic        model_lg = 1'b1;
    int          mcnt [2] = '{0, 0};
    txn_t        q0[$], q1[$];
    exp_t        exp_q[$];
    int          acc_cyc[$];
    logic        acc_id[$];

    function automatic logic [15:0] mm_rd(input logic [15:0] a);
        return mm.exists(int'(a)) ? mm[int'(a)] : 16'h0;
    endfunction

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        mem[a] <= d;
        mm[int'(a)] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; s_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_lg = 1'b1;
        mcnt[0] = 0; mcnt[1] = 0;
    endtask

    // Expected service order from round-robin rules, assuming both queues are presented continuously.
    task automatic build_expect();
        txn_t c0[$] = q0;
        txn_t c1[$] = q1;
        txn_t t;
        logic g;
        logic [15:0] d;
        exp_q.delete();
        while (c0.size() != 0 || c1.size() != 0) begin
            if (c0.size() != 0 && c1.size() != 0) g = ~model_lg;
            else g = (c0.size() == 0);
            t = g ? c1.pop_front() : c0.pop_front();
            d = t.we ? 16'h0 : mm_rd(t.addr);
            if (t.we) mm[int'(t.addr)] = t.wdata;
            exp_q.push_back('{g, d});
            model_lg = g;
            mcnt[g] = mcnt[g] + 1;
        end
    endtask

    task automatic drive_queues();
        int guard = 0;
        logic [1:0] rdy;
        int ta;
        acc_cyc.delete(); acc_id.delete();
        while ((q0.size() != 0 || q1.size() != 0) && guard < 500) begin
            @(negedge clk);
            req_valid[0] = (q0.size() != 0);
            req_valid[1] = (q1.size() != 0);
            if (q0.size() != 0) begin
                req_we[0] = q0[0].we; req_addr[15:0] = q0[0].addr; req_wdata[15:0] = q0[0].wdata;
            end
            if (q1.size() != 0) begin
                req_we[1] = q1[0].we; req_addr[31:16] = q1[0].addr; req_wdata[31:16] = q1[0].wdata;
            end
            #1;
            rdy = req_ready;
            ta = cyc;
            @(posedge clk);
            if (req_valid[0] && rdy[0]) begin acc_cyc.push_back(ta); acc_id.push_back(1'b0); void'(q0.pop_front()); end
            if (req_valid[1] && rdy[1]) begin acc_cyc.push_back(ta); acc_id.push_back(1'b1); void'(q1.pop_front()); end
            guard++;
        end
        checks++;
        if (guard >= 500) begin
            errors++;
            $display("FAIL drive_timeout: pending q0=%0d q1=%0d, required 0", q0.size(), q1.size());
            q0.delete(); q1.delete();
        end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", req_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL rst_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_rdata !== 16'h0) begin errors++; $display("FAIL rst_rsp: got %b %b %h want 0 0 0", rsp_valid, rsp_id, rsp_rdata); end
        checks++; if (grant_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h want 0", grant_cnt); end
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_first_tie: got %b want 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_single_read();
        preload(16'h0010, 16'hAB12);
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b00; req_addr[15:0] = 16'h0010;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL sr_ready: got %b want 01", req_ready); end
        @(posedge clk);
        model_lg = 1'b0; mcnt[0] = mcnt[0] + 1;
        @(negedge clk);
        req_valid = 2'b00;
        checks++; if (mem_addr !== 16'h0010 || mem_we !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL sr_access: got addr %h we %b rv %b want 0010 0 0", mem_addr, mem_we, rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_rdata !== 16'hAB12) begin errors++; $display("FAIL sr_resp: got %b %b %h want 1 0 ab12", rsp_valid, rsp_id, rsp_rdata); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sr_pulse: got %b want 0", rsp_valid); end
    endtask

    task automatic test_write_read();
        int n0, w0;
        q1.push_back('{1'b1, 16'h0003, 16'h5A5A});
        q1.push_back('{1'b0, 16'h0003, 16'h0000});
        build_expect();
        n0 = rq.size(); w0 = we_cycles;
        drive_queues();
        checks++; if (rq.size() - n0 !== 2) begin errors++; $display("FAIL wr_count: got %0d want 2", rq.size() - n0); end
        for (int i = 0; i < 2 && n0 + i < rq.size(); i++) begin
            checks++;
            if (rq[n0+i].id !== exp_q[i].id || rq[n0+i].data !== exp_q[i].data) begin
                errors++; $display("FAIL wr_rsp%0d: got id %b data %h want id %b data %h", i, rq[n0+i].id, rq[n0+i].data, exp_q[i].id, exp_q[i].data);
            end
        end
        checks++; if (we_cycles - w0 !== 1) begin errors++; $display("FAIL wr_we_len: got %0d want 1", we_cycles - w0); end
    endtask

    task automatic test_stall();
        preload(16'h0020, 16'h1234);
        preload(16'h0021, 16'h4321);
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b00; req_addr = {16'h0000, 16'h0020};
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL st_ready0: got %b want 01", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b11; req_addr = {16'h0021, 16'h0020};
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL st_access_ready: got %b want 00", req_ready); end
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL st_resp_ready: got %b want 00", req_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_rdata !== 16'h1234) begin errors++; $display("FAIL st_rsp0: got %b %b %h want 1 0 1234", rsp_valid, rsp_id, rsp_rdata); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL st_idle_ready: got %b want 10", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        checks++; if (mem_addr !== 16'h0021) begin errors++; $display("FAIL st_addr1: got %h want 0021", mem_addr); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_rdata !== 16'h4321) begin errors++; $display("FAIL st_rsp1: got %b %b %h want 1 1 4321", rsp_valid, rsp_id, rsp_rdata); end
        @(negedge clk);
        model_lg = 1'b1; mcnt[0] = mcnt[0] + 1; mcnt[1] = mcnt[1] + 1;
    endtask

    task automatic test_reset_mid();
        int n0;
        preload(16'h0040, 16'h1111);
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01; req_addr[15:0] = 16'h0040; req_wdata[15:0] = 16'hBEEF;
        @(posedge clk);
        #2;
        req_valid = 2'b00;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rm_we_high: got %b want 1", mem_we); end
        n0 = rq.size();
        rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rm_we_drop: got %b want 0", mem_we); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_lg = 1'b1; mcnt[0] = 0; mcnt[1] = 0;
        repeat (4) @(negedge clk);
        checks++; if (rq.size() !== n0) begin errors++; $display("FAIL rm_no_rsp: got %0d responses want 0", rq.size() - n0); end
        checks++; if (grant_cnt !== 32'h0) begin errors++; $display("FAIL rm_cnt: got %h want 0", grant_cnt); end
        checks++; if (mem[16'h0040] !== 16'h1111) begin errors++; $display("FAIL rm_mem: got %h want 1111", mem[16'h0040]); end
        req_valid = 2'b11; req_we = 2'b00;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_tie: got %b want 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_contention();
        int n0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom)});
            q1.push_back('{1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'($urandom)});
        end
        build_expect();
        n0 = rq.size();
        drive_queues();
        checks++; if (acc_id.size() !== 8 || rq.size() - n0 !== 8) begin errors++; $display("FAIL ct_count: got %0d/%0d want 8/8", acc_id.size(), rq.size() - n0); end
        for (int i = 0; i < 8 && i < acc_id.size() && n0 + i < rq.size(); i++) begin
            checks++;
            if (acc_id[i] !== 1'(i % 2) || rq[n0+i].id !== exp_q[i].id || rq[n0+i].data !== exp_q[i].data) begin
                errors++; $display("FAIL ct_txn%0d: got grant %b rsp %b/%h want %b %b/%h", i, acc_id[i], rq[n0+i].id, rq[n0+i].data, 1'(i % 2), exp_q[i].id, exp_q[i].data);
            end
            checks++;
            if (rq[n0+i].t - acc_cyc[i] !== 2 || (i > 0 && acc_cyc[i] - acc_cyc[i-1] !== 3)) begin
                errors++; $display("FAIL ct_timing%0d: got accept %0d rsp %0d", i, acc_cyc[i], rq[n0+i].t);
            end
        end
        checks++; if (grant_cnt !== {16'd4, 16'd4}) begin errors++; $display("FAIL ct_cnt: got %h want 00040004", grant_cnt); end
    endtask

    task automatic test_random();
        int n0, l0, l1;
        for (int r = 0; r < 6; r++) begin
            l0 = $urandom_range(0, 5);
            l1 = $urandom_range(1, 5);
            for (int i = 0; i < l0; i++) q0.push_back('{1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom)});
            for (int i = 0; i < l1; i++) q1.push_back('{1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom)});
            build_expect();
            n0 = rq.size();
            drive_queues();
            checks++; if (rq.size() - n0 !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", r, rq.size() - n0, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && n0 + i < rq.size(); i++) begin
                checks++;
                if (rq[n0+i].id !== exp_q[i].id || rq[n0+i].data !== exp_q[i].data) begin
                    errors++; $display("FAIL rnd%0d_rsp%0d: got %b/%h want %b/%h", r, i, rq[n0+i].id, rq[n0+i].data, exp_q[i].id, exp_q[i].data);
                end
            end
            checks++;
            if (grant_cnt !== {16'(mcnt[1]), 16'(mcnt[0])}) begin
                errors++; $display("FAIL rnd%0d_cnt: got %h want %04h%04h", r, grant_cnt, 16'(mcnt[1]), 16'(mcnt[0]));
            end
        end
    endtask

    task automatic test_saturation();
        int acc = 0;
        int guard = 0;
        logic rdy;
        do_reset();
        s_valid = 2'b01;
        while (acc < 5 && guard < 60) begin
            #1;
            rdy = s_ready[0];
            @(posedge clk);
            @(negedge clk);
            if (rdy) begin
                acc++;
                checks++;
                if (s_cnt[1:0] !== 2'((acc > 3) ? 3 : acc)) begin
                    errors++; $display("FAIL sat_step%0d: got %0d want %0d", acc, s_cnt[1:0], (acc > 3) ? 3 : acc);
                end
            end
            guard++;
        end
        s_valid = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if (acc !== 5) begin errors++; $display("FAIL sat_accepts: got %0d want 5", acc); end
        checks++; if (s_cnt !== 4'b0011) begin errors++; $display("FAIL sat_final: got %b want 0011", s_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] <= 16'h0;
        test_reset();
        test_single_read();
        test_write_read();
        test_stall();
        test_reset_mid();
        test_contention();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
